// File: rtl/seg7_rx.sv
// rtl/seg7_rx.sv - recovers a 4-digit hex value from a multiplexed 7-segment drive
module seg7_rx #(
    parameter int STABLE_CYC = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [6:0]  iSEG7,
    input  logic [3:0]  iDIG,
    input  logic        iCLR,
    output logic [15:0] oHex,
    output logic [3:0]  oVALID,
    output logic        oUPD,
    output logic        oERR
);

    typedef enum logic [1:0] {S_WAIT, S_COMMIT, S_HOLD} state_t;

    // Counter holds (identical samples seen - 1); COMMIT is entered on the
    // edge where the STABLE_CYC-th identical sample arrives.
    localparam logic [7:0] CNT_GO  = 8'(STABLE_CYC - 2);
    localparam logic [7:0] CNT_MAX = 8'hFF;

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_samp;
    logic [7:0]  r_cnt;
    logic        r_fresh;
    logic [10:0] w_in;
    logic        w_same;
    logic        w_ready;
    logic [3:0]  w_dig;
    logic        w_onehot;
    logic        w_legal;
    logic        w_blank;
    logic [3:0]  w_nib;

    assign w_in     = {iDIG, iSEG7};
    // The first sample after reset is always treated as a new value.
    assign w_same   = !r_fresh && (w_in == r_samp);
    assign w_ready  = w_same && (r_cnt >= CNT_GO);
    assign w_dig    = r_samp[10:7];
    assign w_onehot = (w_dig != 4'd0) && ((w_dig & (w_dig - 4'd1)) == 4'd0);

    // Sample register and saturating stability counter.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_samp  <= '0;
            r_cnt   <= '0;
            r_fresh <= 1'b1;
        end else begin
            r_samp  <= w_in;
            r_fresh <= 1'b0;
            if (!w_same)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge iCLK) begin
        if (iRST)
            r_state <= S_WAIT;
        else
            r_state <= w_next;
    end

    // Next-state logic. A change landing on the COMMIT->HOLD edge leaves the
    // counter at 0 in HOLD, so HOLD also resumes counting when it sees that.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT:   if (w_ready) w_next = S_COMMIT;
            S_COMMIT: w_next = S_HOLD;
            S_HOLD: begin
                if (!w_same)
                    w_next = S_WAIT;
                else if (r_cnt == 8'd0)
                    w_next = w_ready ? S_COMMIT : S_WAIT;
            end
            default:  w_next = S_WAIT;
        endcase
    end

    // Segment pattern decode of the held sample.
    always_comb begin
        w_legal = 1'b1;
        w_blank = 1'b0;
        w_nib   = 4'h0;
        case (r_samp[6:0])
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            7'h00: begin
                w_legal = 1'b0;
                w_blank = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Result registers: clear beats commit; only the selected digit changes.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oHex   <= '0;
            oVALID <= '0;
            oUPD   <= 1'b0;
            oERR   <= 1'b0;
        end else begin
            oUPD <= 1'b0;
            if (iCLR) begin
                oHex   <= '0;
                oVALID <= '0;
                oERR   <= 1'b0;
            end else if (r_state == S_COMMIT && w_onehot) begin
                oUPD <= 1'b1;
                if (!w_legal && !w_blank)
                    oERR <= 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (w_dig[k]) begin
                        if (w_legal) begin
                            oHex[4*k +: 4] <= w_nib;
                            oVALID[k]      <= 1'b1;
                        end else if (w_blank) begin
                            oVALID[k]      <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_rx.sv
// tb/tb_seg7_rx.sv - directed self-checking bench for seg7_rx
module tb_seg7_rx;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [6:0]  iSEG7;
    logic [3:0]  iDIG;
    logic        iCLR;
    logic [15:0] oHex;
    logic [3:0]  oVALID;
    logic        oUPD;
    logic        oERR;

    int n_checks = 0;
    int n_errors = 0;
    int n_upd    = 0;

    seg7_rx #(.STABLE_CYC(4)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iSEG7  (iSEG7),
        .iDIG   (iDIG),
        .iCLR   (iCLR),
        .oHex   (oHex),
        .oVALID (oVALID),
        .oUPD   (oUPD),
        .oERR   (oERR)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) if (oUPD === 1'b1) n_upd++;

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic test_reset;
        iRST = 1'b1; iCLR = 1'b0; iDIG = 4'h0; iSEG7 = 7'h00;
        tick(2);
        n_checks++;
        if ({oHex, oVALID, oUPD, oERR} !== 22'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got hex=%h val=%b upd=%b err=%b expected all zero", oHex, oVALID, oUPD, oERR);
        end
        iRST = 1'b0;
    endtask

    task automatic test_single_digit;
        int u0;
        u0 = n_upd;
        iDIG = 4'b0001; iSEG7 = 7'h4F;
        tick(4);
        n_checks++;
        if (oUPD !== 1'b0 || oHex !== 16'h0000) begin
            n_errors++;
            $display("FAIL single_early: got upd=%b hex=%h expected 0 0000", oUPD, oHex);
        end
        tick(1);
        n_checks++;
        if (oUPD !== 1'b1 || oHex !== 16'h0003 || oVALID !== 4'b0001) begin
            n_errors++;
            $display("FAIL single_commit: got upd=%b hex=%h val=%b expected 1 0003 0001", oUPD, oHex, oVALID);
        end
        tick(5);
        n_checks++;
        if (n_upd - u0 !== 1) begin
            n_errors++;
            $display("FAIL single_pulses: got %0d expected 1", n_upd - u0);
        end
    endtask

    task automatic test_sequence;
        int u0;
        logic [3:0] digs [3];
        logic [6:0] segs [3];
        u0 = n_upd;
        digs[0] = 4'b0010; segs[0] = 7'h77;
        digs[1] = 4'b0100; segs[1] = 7'h5E;
        digs[2] = 4'b1000; segs[2] = 7'h79;
        for (int i = 0; i < 3; i++) begin
            iDIG = digs[i]; iSEG7 = segs[i];
            tick(6);
        end
        n_checks++;
        if (oHex !== 16'hEDA3 || oVALID !== 4'b1111) begin
            n_errors++;
            $display("FAIL seq_value: got hex=%h val=%b expected EDA3 1111", oHex, oVALID);
        end
        n_checks++;
        if (n_upd - u0 !== 3) begin
            n_errors++;
            $display("FAIL seq_pulses: got %0d expected 3", n_upd - u0);
        end
    endtask

    task automatic test_unstable;
        int u0;
        u0 = n_upd;
        iDIG = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            iSEG7 = (i % 2 == 0) ? 7'h06 : 7'h07;
            tick(2);
        end
        n_checks++;
        if (n_upd - u0 !== 0 || oHex !== 16'hEDA3) begin
            n_errors++;
            $display("FAIL unstable_nocommit: got pulses=%0d hex=%h expected 0 EDA3", n_upd - u0, oHex);
        end
        iSEG7 = 7'h07;
        tick(6);
        n_checks++;
        if (oHex !== 16'hE7A3 || n_upd - u0 !== 1) begin
            n_errors++;
            $display("FAIL unstable_settle: got hex=%h pulses=%0d expected E7A3 1", oHex, n_upd - u0);
        end
    endtask

    task automatic test_blank_illegal;
        int u0;
        u0 = n_upd;
        iDIG = 4'b0010; iSEG7 = 7'h00;
        tick(6);
        n_checks++;
        if (oVALID !== 4'b1101 || oHex !== 16'hE7A3 || oERR !== 1'b0) begin
            n_errors++;
            $display("FAIL blank: got val=%b hex=%h err=%b expected 1101 E7A3 0", oVALID, oHex, oERR);
        end
        iSEG7 = 7'h12;
        tick(6);
        n_checks++;
        if (oERR !== 1'b1 || oVALID !== 4'b1101 || oHex !== 16'hE7A3) begin
            n_errors++;
            $display("FAIL illegal: got err=%b val=%b hex=%h expected 1 1101 E7A3", oERR, oVALID, oHex);
        end
        n_checks++;
        if (n_upd - u0 !== 2) begin
            n_errors++;
            $display("FAIL blank_illegal_pulses: got %0d expected 2", n_upd - u0);
        end
        iDIG = 4'b0001; iSEG7 = 7'h3F;
        tick(6);
        n_checks++;
        if (oERR !== 1'b1 || oHex !== 16'hE7A0) begin
            n_errors++;
            $display("FAIL err_sticky: got err=%b hex=%h expected 1 E7A0", oERR, oHex);
        end
    endtask

    task automatic test_not_onehot;
        int u0;
        u0 = n_upd;
        iDIG = 4'b0011; iSEG7 = 7'h06;
        tick(6);
        iDIG = 4'b0000; iSEG7 = 7'h7F;
        tick(6);
        n_checks++;
        if (oHex !== 16'hE7A0 || oVALID !== 4'b1101 || n_upd - u0 !== 0) begin
            n_errors++;
            $display("FAIL not_onehot: got hex=%h val=%b pulses=%0d expected E7A0 1101 0", oHex, oVALID, n_upd - u0);
        end
    endtask

    task automatic test_clear_in_commit;
        int u0;
        u0 = n_upd;
        iDIG = 4'b0001; iSEG7 = 7'h06;
        tick(4);
        iCLR = 1'b1;
        tick(1);
        iCLR = 1'b0;
        n_checks++;
        if ({oHex, oVALID, oUPD, oERR} !== 22'h0) begin
            n_errors++;
            $display("FAIL clear_commit: got hex=%h val=%b upd=%b err=%b expected all zero", oHex, oVALID, oUPD, oERR);
        end
        tick(8);
        n_checks++;
        if (oHex !== 16'h0000 || n_upd - u0 !== 0) begin
            n_errors++;
            $display("FAIL clear_no_recommit: got hex=%h pulses=%0d expected 0000 0", oHex, n_upd - u0);
        end
    endtask

    task automatic test_long_hold;
        int u0;
        u0 = n_upd;
        iDIG = 4'b1000; iSEG7 = 7'h6F;
        tick(300);
        n_checks++;
        if (oHex !== 16'h9000 || oVALID !== 4'b1000 || n_upd - u0 !== 1) begin
            n_errors++;
            $display("FAIL long_hold: got hex=%h val=%b pulses=%0d expected 9000 1000 1", oHex, oVALID, n_upd - u0);
        end
    endtask

    task automatic test_reset_midcount;
        int u0;
        iDIG = 4'b0100; iSEG7 = 7'h7F;
        tick(2);
        iRST = 1'b1;
        tick(1);
        n_checks++;
        if ({oHex, oVALID, oUPD, oERR} !== 22'h0) begin
            n_errors++;
            $display("FAIL reset_mid: got hex=%h val=%b upd=%b err=%b expected all zero", oHex, oVALID, oUPD, oERR);
        end
        tick(2);
        u0 = n_upd;
        iRST = 1'b0;
        tick(4);
        n_checks++;
        if (oUPD !== 1'b0 || oHex !== 16'h0000 || n_upd - u0 !== 0) begin
            n_errors++;
            $display("FAIL reset_lost_commit: got upd=%b hex=%h pulses=%0d expected 0 0000 0", oUPD, oHex, n_upd - u0);
        end
        tick(1);
        n_checks++;
        if (oUPD !== 1'b1 || oHex !== 16'h0800 || oVALID !== 4'b0100) begin
            n_errors++;
            $display("FAIL reset_recount: got upd=%b hex=%h val=%b expected 1 0800 0100", oUPD, oHex, oVALID);
        end
    endtask

    initial begin
        test_reset;
        test_single_digit;
        test_sequence;
        test_unstable;
        test_blank_illegal;
        test_not_onehot;
        test_clear_in_commit;
        test_long_hold;
        test_reset_midcount;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_rx.md
SEG7_RX -- requirements
Module: seg7_rx

Interface
REQ-001 Parameter STABLE_CYC, default 4, legal 2..255: consecutive identical samples required before a digit is accepted.
REQ-002 iCLK  input  1  single clock; all state changes on the rising edge.
REQ-003 iRST  input  1  reset, synchronous, active-high.
REQ-004 iSEG7  input  7  segment pattern, active-high; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-005 iDIG  input  4  digit enable, one-hot; bit k selects display position k (k=0 is least significant).
REQ-006 iCLR  input  1  synchronous clear of captured results, active-high.
REQ-007 oHex  output  16  recovered hex value; nibble k = oHex[4k+3:4k].
REQ-008 oVALID  output  4  bit k high when nibble k holds a legally decoded digit.
REQ-009 oUPD  output  1  one-cycle pulse on every accepted commit.
REQ-010 oERR  output  1  sticky flag; an illegal pattern was committed on a one-hot digit.

Function
REQ-011 Decode table (iSEG7 -> nibble) SHALL be 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9, 0x77->A, 0x7C->B, 0x39->C, 0x5E->D, 0x79->E, 0x71->F.
REQ-012 Pattern 0x00 is BLANK; all other patterns not listed in REQ-011 are ILLEGAL.
REQ-013 {iDIG, iSEG7} SHALL be registered into a sample register every cycle; the stability counter compares each new sample with the previous sample.
REQ-014 The FSM SHALL have three states: WAIT (counting identical samples), COMMIT (one cycle, outputs updated), and HOLD (committed; waiting for the input to change).
REQ-015 WAIT: a sample that differs from the previous sample resets the counter to 0; after STABLE_CYC identical samples, the FSM SHALL go to COMMIT.
REQ-016 COMMIT -> HOLD unconditionally; HOLD -> WAIT (counter 0) on the first differing sample; no second commit occurs without an input change.
REQ-017 Latency: if the inputs are first sampled with a new value at edge t and held, the commit results SHALL be visible after edge t+STABLE_CYC, and oUPD SHALL be high for exactly that one cycle.
REQ-018 Commit with one-hot iDIG (bit k) and a legal pattern: nibble k <= decoded value, oVALID[k] <= 1, oUPD pulse.
REQ-019 Commit with one-hot iDIG (bit k) and BLANK: oVALID[k] <= 0, nibble k unchanged, oUPD pulse.
REQ-020 Commit with one-hot iDIG (bit k) and ILLEGAL: oERR <= 1, nibble k and oVALID[k] unchanged, oUPD pulse.
REQ-021 Commit with iDIG zero or not one-hot: no output change and no oUPD pulse; the FSM still goes to HOLD.
REQ-022 Other nibbles and oVALID bits SHALL be untouched by any commit.
REQ-023 iCLR SHALL set oHex=0, oVALID=0, and oERR=0 on the next edge without affecting the sample register or the counter.
REQ-024 iCLR asserted in the COMMIT cycle takes priority: the commit is discarded, oUPD stays low, and the FSM goes to HOLD.
REQ-025 The counter SHALL saturate and never wrap; a held input produces exactly one commit regardless of hold length.

Reset
REQ-026 On iRST high at an edge: oHex=0, oVALID=0, oUPD=0, oERR=0, sample register=0, counter=0, FSM=WAIT.
REQ-027 iRST has priority over iCLR and over any pending commit; a commit in progress is lost.
REQ-028 After iRST deasserts, inputs sampled at the first subsequent edge count as a new value.

Verification (STABLE_CYC=4)
REQ-029 iDIG=0001, iSEG7=0x4F held 10 cycles -> oHex=0x0003, oVALID=0001, exactly one oUPD pulse, 4 cycles after the first sampling edge.
REQ-030 Sequence digit1=0x77, digit2=0x5E, digit3=0x79, each held 6 cycles -> oHex=0xEDA3 (with REQ-029 first), oVALID=1111, three oUPD pulses.
REQ-031 iSEG7 toggling 0x06/0x07 every 2 cycles on iDIG=0100 -> no commit and no oUPD; then 0x07 held -> nibble2=7.
REQ-032 iDIG=0010, iSEG7=0x00 held -> oVALID[1]=0, nibble1 unchanged; iDIG=0010, iSEG7=0x12 held -> oERR=1 and remains set until iCLR.
REQ-033 iDIG=0011 with a legal pattern held -> no change; iCLR pulsed in the COMMIT cycle -> all outputs 0 and no oUPD; iRST mid-count -> all outputs 0 with no commit.
